// File: rtl/lsu_pkg.sv
// Shared types and constants for the lsu_mmio load/store unit.
// LSU_MISALIGN_TRAP_EN (in lsu_mmio) selects trapping instead of forced alignment.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_OUT  = 2'd1,
        REG_IN   = 2'd2,
        REG_RSVD = 2'd3
    } lsu_region_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [31:0] DATA_BASE  = 32'h0000_0000;
    localparam logic [31:0] DATA_LIMIT = 32'h0000_03FF;
    localparam logic [31:0] OUT_BASE   = 32'h0000_0400;
    localparam logic [31:0] OUT_LIMIT  = 32'h0000_04FF;
    localparam logic [31:0] IN_BASE    = 32'h0000_0500;
    localparam logic [31:0] IN_LIMIT   = 32'h0000_05FF;

    // Byte-lane enables for a store, taken from the already-aligned low address bits.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (f3)
            LSU_B:   be = 4'b0001 << lo;
            LSU_H:   be = lo[1] ? 4'b1100 : 4'b0011;
            LSU_W:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane select and sign/zero extension of a 32-bit word for RV32I loads.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = 32'h0;
        case (funct3_i)
            LSU_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  data_o = {24'h0, byte_sel};
            LSU_H:   data_o = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  data_o = {16'h0, half_sel};
            LSU_W:   data_o = word_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mmio.sv
// Memory-mapped LSU: data RAM, output registers and synchronised switches behind one request port.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module lsu_mmio
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = 256,
    parameter int NUM_OUT    = 11,
    parameter int SW_W       = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    input  logic [SW_W-1:0]       io_sw_i,
    output logic [NUM_OUT*32-1:0] io_out_o
);

    // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
    // the response strobe follows two cycles later and cannot be stalled.

    localparam int AW = $clog2(DMEM_WORDS);
    localparam logic [8:0] DMEM_WORDS_L = 9'(DMEM_WORDS);
    localparam logic [6:0] NUM_OUT_L    = 7'(NUM_OUT);

    lsu_state_e state_q, state_d;
    logic       accept;

    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] wdata_q;
    lsu_region_e region_q, region_d;
    logic        err_q, err_d;

    logic [31:0]     dmem [DMEM_WORDS];
    logic [31:0]     ram_rdata_q;
    logic [31:0]     out_q [NUM_OUT];
    logic [SW_W-1:0] sw_s1_q, sw_s2_q;

    logic        rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        op_bad, misal, do_write;
    logic [31:0] addr_al;
    logic [3:0]  be;
    logic [31:0] wd_lanes, out_rd, sw_word, ld_word, ld_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = ST_ACCESS;
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                req_ready_o = 1'b1;
                state_d     = req_valid_i ? ST_ACCESS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst_i) req_ready_o = 1'b0;
    end

    assign accept = req_valid_i && req_ready_o;

    // Request decode, done on the raw address before it is captured.
    always_comb begin
        case (req_funct3_i)
            LSU_B, LSU_H, LSU_W: op_bad = 1'b0;
            LSU_BU, LSU_HU:      op_bad = req_we_i;
            default:             op_bad = 1'b1;
        endcase
        misal = (((req_funct3_i == LSU_H) || (req_funct3_i == LSU_HU)) && req_addr_i[0])
             || ((req_funct3_i == LSU_W) && (req_addr_i[1:0] != 2'b00));

        addr_al = req_addr_i;
`ifndef LSU_MISALIGN_TRAP_EN
        if ((req_funct3_i == LSU_H) || (req_funct3_i == LSU_HU)) addr_al[0] = 1'b0;
        if (req_funct3_i == LSU_W) addr_al[1:0] = 2'b00;
`endif

        if (req_addr_i <= DATA_LIMIT)
            region_d = ({1'b0, req_addr_i[9:2]} < DMEM_WORDS_L) ? REG_DATA : REG_RSVD;
        else if ((req_addr_i >= OUT_BASE) && (req_addr_i <= OUT_LIMIT))
            region_d = ({1'b0, req_addr_i[7:2]} < NUM_OUT_L) ? REG_OUT : REG_RSVD;
        else if ((req_addr_i >= IN_BASE) && (req_addr_i <= IN_LIMIT))
            region_d = REG_IN;
        else
            region_d = REG_RSVD;

        err_d = op_bad || (region_d == REG_RSVD) || ((region_d == REG_IN) && req_we_i);
`ifdef LSU_MISALIGN_TRAP_EN
        err_d = err_d || misal;
`endif
        we_d   = req_we_i;
        f3_d   = req_funct3_i;
        addr_d = addr_al[9:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            region_q <= REG_DATA;
            err_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= req_wdata_i;
            region_q <= region_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        case (f3_q)
            LSU_B:   wd_lanes = {4{wdata_q[7:0]}};
            LSU_H:   wd_lanes = {2{wdata_q[15:0]}};
            default: wd_lanes = wdata_q;
        endcase
        be       = store_be(f3_q, addr_q[1:0]);
        do_write = (state_q == ST_ACCESS) && we_q && !err_q && !rst_i;
    end

    // RAM is not reset; the read at accept lands in ram_rdata_q for the ACCESS cycle.
    always_ff @(posedge clk_i) begin
        if (accept) ram_rdata_q <= dmem[addr_d[AW+1:2]];
        if (do_write && (region_q == REG_DATA)) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) dmem[addr_q[AW+1:2]][8*b +: 8] <= wd_lanes[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
        end else if (do_write && (region_q == REG_OUT)) begin
            for (int k = 0; k < NUM_OUT; k++)
                if (addr_q[7:2] == 6'(k))
                    for (int b = 0; b < 4; b++)
                        if (be[b]) out_q[k][8*b +: 8] <= wd_lanes[8*b +: 8];
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign io_out_o[32*k +: 32] = out_q[k];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= io_sw_i;
            sw_s2_q <= sw_s1_q;
        end
    end

    always_comb begin
        out_rd = '0;
        for (int k = 0; k < NUM_OUT; k++)
            if (addr_q[7:2] == 6'(k)) out_rd = out_q[k];
        sw_word = '0;
        sw_word[SW_W-1:0] = sw_s2_q;
        case (region_q)
            REG_DATA: ld_word = ram_rdata_q;
            REG_OUT:  ld_word = out_rd;
            REG_IN:   ld_word = sw_word;
            default:  ld_word = '0;
        endcase
    end

    lsu_load_align u_align (
        .word_i    (ld_word),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= (state_q == ST_ACCESS);
            if (state_q == ST_ACCESS) begin
                rsp_rdata_q <= (err_q || we_q) ? 32'h0 : ld_data;
                rsp_err_q   <= err_q;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio against a byte-addressed reference model.
module tb_lsu_mmio;

    localparam int DMEM_WORDS = 256;
    localparam int NUM_OUT    = 11;
    localparam int SW_W       = 17;

    logic                  clk;
    logic                  rst_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_funct3_i;
    logic [31:0]           req_addr_i;
    logic [31:0]           req_wdata_i;
    logic                  rsp_valid_o;
    logic [31:0]           rsp_rdata_o;
    logic                  rsp_err_o;
    logic [SW_W-1:0]       io_sw_i;
    logic [NUM_OUT*32-1:0] io_out_o;

    int checks = 0;
    int errors = 0;

    // Model state: bytes 0x000-0x4FF (data then output registers) and the switch word.
    logic [7:0]  sp [0:1535];
    logic [31:0] sw_m;
    logic [31:0] exp_q [$];
    logic        exp_err_q [$];

    lsu_mmio #(.DMEM_WORDS(DMEM_WORDS), .NUM_OUT(NUM_OUT), .SW_W(SW_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .io_sw_i(io_sw_i), .io_out_o(io_out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_access(input logic we, input logic [2:0] f3, input logic [31:0] a_in,
                                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size; bit sgn; bit legal; bit mis; int region; int base;
        logic [31:0] a; logic [31:0] v;
        a = a_in; size = 1; sgn = 0; legal = 1; rd = 32'h0;
        case (f3)
            3'b000: begin size = 1; sgn = 1; end
            3'b001: begin size = 2; sgn = 1; end
            3'b010: size = 4;
            3'b100: begin size = 1; legal = !we; end
            3'b101: begin size = 2; legal = !we; end
            default: legal = 0;
        endcase
        if (a < 32'h400)      region = (int'(a >> 2) < DMEM_WORDS) ? 0 : 3;
        else if (a < 32'h500) region = (int'((a - 32'h400) >> 2) < NUM_OUT) ? 1 : 3;
        else if (a < 32'h600) region = 2;
        else                  region = 3;
        mis = (int'(a[1:0]) % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) legal = 0;
`else
        if (mis) a[1:0] = 2'(int'(a[1:0]) - (int'(a[1:0]) % size));
`endif
        er = !legal || (region == 3) || (region == 2 && we);
        if (er) return;
        base = int'(a[10:0]);
        if (we) begin
            for (int i = 0; i < size; i++) sp[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++)
                v[8*i +: 8] = (region == 2) ? sw_m[8*(int'(a[1:0]) + i) +: 8] : sp[base + i];
            if (sgn && v[8*size-1])
                for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
            rd = v;
        end
    endfunction

    function automatic logic [NUM_OUT*32-1:0] exp_io_out();
        logic [NUM_OUT*32-1:0] v;
        for (int k = 0; k < NUM_OUT; k++)
            for (int b = 0; b < 4; b++) v[32*k + 8*b +: 8] = sp[1024 + 4*k + b];
        return v;
    endfunction

    task automatic clear_out_model();
        for (int i = 1024; i < 1280; i++) sp[i] = 8'h00;
    endtask

    // Drive one request, then observe the response window; lat = cycle of first strobe.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int nval);
        int n;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        lat = 0; nval = 0; rd = 32'h0; er = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1) begin
                nval++;
                if (lat == 0) begin lat = c; rd = rsp_rdata_o; er = rsp_err_o; end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b010;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; io_sw_i = '0; sw_m = 32'h0;
        for (int i = 0; i < 1536; i++) sp[i] = 8'h00;
        repeat (2) begin
            @(negedge clk);
            checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", req_ready_o); end
        end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata_o); end
        checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err_o); end
        checks++; if (io_out_o !== '0) begin errors++; $display("FAIL reset_io_out got %h want 0", io_out_o); end
        rst_i = 1'b0;
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", req_ready_o); end
    endtask

    task automatic test_subword();
        logic [31:0] rd, mrd; logic er, mer; int lat, nv;
        logic [2:0] f3s [4]; logic [31:0] adr [4]; logic [31:0] exv [4];
        f3s[0] = 3'b000; adr[0] = 32'h010; exv[0] = 32'hFFFF_FFFF;
        f3s[1] = 3'b100; adr[1] = 32'h011; exv[1] = 32'h0000_0080;
        f3s[2] = 3'b001; adr[2] = 32'h012; exv[2] = 32'hFFFF_8000;
        f3s[3] = 3'b101; adr[3] = 32'h012; exv[3] = 32'h0000_8000;
        model_access(1'b1, 3'b010, 32'h010, 32'h8000_80FF, mrd, mer);
        access(1'b1, 3'b010, 32'h010, 32'h8000_80FF, rd, er, lat, nv);
        checks++; if (er !== 1'b0 || lat != 2) begin errors++; $display("FAIL sw_store err %b lat %0d want err 0 lat 2", er, lat); end
        for (int i = 0; i < 4; i++) begin
            model_access(1'b0, f3s[i], adr[i], 32'h0, mrd, mer);
            access(1'b0, f3s[i], adr[i], 32'h0, rd, er, lat, nv);
            checks++; if (rd !== exv[i] || er !== 1'b0) begin errors++; $display("FAIL subword_load%0d got %h err %b want %h err 0", i, rd, er, exv[i]); end
            checks++; if (rd !== mrd) begin errors++; $display("FAIL subword_model%0d got %h want %h", i, rd, mrd); end
            checks++; if (lat != 2 || nv != 1) begin errors++; $display("FAIL subword_timing%0d lat %0d strobes %0d want 2 and 1", i, lat, nv); end
        end
    endtask

    task automatic test_out_port();
        logic [31:0] rd, mrd; logic er, mer; int lat, nv;
        model_access(1'b1, 3'b000, 32'h405, 32'h0000_00A5, mrd, mer);
        access(1'b1, 3'b000, 32'h405, 32'h0000_00A5, rd, er, lat, nv);
        checks++; if (io_out_o[63:32] !== 32'h0000_A500) begin errors++; $display("FAIL out_reg1 got %h want 0000a500", io_out_o[63:32]); end
        checks++; if (io_out_o !== exp_io_out()) begin errors++; $display("FAIL out_all got %h want %h", io_out_o, exp_io_out()); end
        access(1'b0, 3'b010, 32'h404, 32'h0, rd, er, lat, nv);
        checks++; if (rd !== 32'h0000_A500 || er !== 1'b0) begin errors++; $display("FAIL out_readback got %h err %b want 0000a500 err 0", rd, er); end
    endtask

    task automatic test_switch();
        logic [31:0] rd, mrd; logic er, mer; int lat, nv;
        @(negedge clk);
        io_sw_i = 17'h1_2345; sw_m = 32'h0001_2345;
        repeat (3) @(negedge clk);
        access(1'b0, 3'b010, 32'h500, 32'h0, rd, er, lat, nv);
        checks++; if (rd !== 32'h0001_2345 || er !== 1'b0) begin errors++; $display("FAIL switch_lw got %h err %b want 00012345 err 0", rd, er); end
        model_access(1'b0, 3'b100, 32'h5F9, 32'h0, mrd, mer);
        access(1'b0, 3'b100, 32'h5F9, 32'h0, rd, er, lat, nv);
        checks++; if (rd !== mrd || er !== mer) begin errors++; $display("FAIL switch_lbu got %h err %b want %h err %b", rd, er, mrd, mer); end
    endtask

    task automatic test_faults();
        logic [31:0] rd, mrd; logic er, mer; int lat, nv;
        access(1'b1, 3'b010, 32'h500, 32'hFFFF_FFFF, rd, er, lat, nv);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin errors++; $display("FAIL store_input got err %b rd %h lat %0d want err 1 rd 0 lat 2", er, rd, lat); end
        checks++; if (io_out_o !== exp_io_out()) begin errors++; $display("FAIL store_input_effect got %h want %h", io_out_o, exp_io_out()); end
        access(1'b0, 3'b010, 32'h700, 32'h0, rd, er, lat, nv);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rsvd_load got err %b rd %h want err 1 rd 0", er, rd); end
        access(1'b0, 3'b011, 32'h010, 32'h0, rd, er, lat, nv);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL funct3_011 got err %b rd %h want err 1 rd 0", er, rd); end
        access(1'b1, 3'b100, 32'h010, 32'h0000_0011, rd, er, lat, nv);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL store_funct3_100 got err %b want 1", er); end
        access(1'b1, 3'b001, 32'h42C, 32'h0000_1234, rd, er, lat, nv);
        checks++; if (er !== 1'b1 || io_out_o !== exp_io_out()) begin errors++; $display("FAIL rsvd_out_idx got err %b out %h want err 1 out %h", er, io_out_o, exp_io_out()); end
        access(1'b0, 3'b010, 32'h010, 32'h0, rd, er, lat, nv);
        checks++; if (rd !== 32'h8000_80FF || er !== 1'b0) begin errors++; $display("FAIL faults_no_write got %h err %b want 800080ff err 0", rd, er); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, mrd; logic er, mer; int lat, nv;
        access(1'b0, 3'b010, 32'h013, 32'h0, rd, er, lat, nv);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_lw got %h err %b want 0 err 1", rd, er); end
`else
        checks++; if (er !== 1'b0 || rd !== 32'h8000_80FF) begin errors++; $display("FAIL misalign_lw got %h err %b want 800080ff err 0", rd, er); end
`endif
        model_access(1'b1, 3'b001, 32'h013, 32'h0000_BEEF, mrd, mer);
        access(1'b1, 3'b001, 32'h013, 32'h0000_BEEF, rd, er, lat, nv);
        checks++; if (er !== mer) begin errors++; $display("FAIL misalign_sh_err got %b want %b", er, mer); end
        model_access(1'b0, 3'b010, 32'h010, 32'h0, mrd, mer);
        access(1'b0, 3'b010, 32'h010, 32'h0, rd, er, lat, nv);
        checks++; if (rd !== mrd || er !== mer) begin errors++; $display("FAIL misalign_sh_effect got %h want %h", rd, mrd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mrd; logic mer;
        model_access(1'b1, 3'b010, 32'h030, 32'hCAFE_F00D, mrd, mer);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = 32'h030; req_wdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_we_i = 1'b0; req_wdata_i = 32'h0;
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_access ready %b valid %b want 0 0", req_ready_o, rsp_valid_o); end
        @(negedge clk);
        checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0 || req_ready_o !== 1'b1)
            begin errors++; $display("FAIL b2b_store_rsp valid %b err %b rd %h ready %b want 1 0 0 1", rsp_valid_o, rsp_err_o, rsp_rdata_o, req_ready_o); end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_gap valid %b want 0", rsp_valid_o); end
        model_access(1'b0, 3'b010, 32'h030, 32'h0, mrd, mer);
        @(negedge clk);
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hCAFE_F00D || rsp_rdata_o !== mrd)
            begin errors++; $display("FAIL b2b_load_rsp valid %b rd %h want 1 cafef00d", rsp_valid_o, rsp_rdata_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd, mrd; logic er, mer; int lat, nv; bit seen;
        model_access(1'b1, 3'b010, 32'h020, 32'h1122_3344, mrd, mer);
        access(1'b1, 3'b010, 32'h020, 32'h1122_3344, rd, er, lat, nv);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = 32'h020; req_wdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0) seen = 1;
            if (c == 1) rst_i = 1'b0;
        end
        clear_out_model();
        checks++; if (seen) begin errors++; $display("FAIL reset_access_rsp got a strobe want none"); end
        access(1'b0, 3'b010, 32'h020, 32'h0, rd, er, lat, nv);
        checks++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin errors++; $display("FAIL reset_access_store got %h want 11223344", rd); end
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h020;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL reset_resp_pre valid %b want 1", rsp_valid_o); end
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid_o !== 1'b0 || io_out_o !== exp_io_out()) begin errors++; $display("FAIL reset_resp_drop valid %b out %h want 0 %h", rsp_valid_o, io_out_o, exp_io_out()); end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, a, wd, e; logic er, mer, ee, we; logic [2:0] f3; int lat, nv;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model_access(1'b1, 3'b010, 32'(4*w), wd, mrd, mer);
            access(1'b1, 3'b010, 32'(4*w), wd, rd, er, lat, nv);
        end
        for (int n = 0; n < 200; n++) begin
            if (n % 50 == 0) begin
                @(negedge clk);
                io_sw_i = SW_W'($urandom);
                sw_m = 32'h0; sw_m[SW_W-1:0] = io_sw_i;
                repeat (4) @(negedge clk);
            end
            case ($urandom_range(0, 4))
                0, 1:    a = 32'($urandom_range(0, 255));
                2:       a = 32'h400 + 32'($urandom_range(0, 63));
                3:       a = 32'h500 + 32'($urandom_range(0, 255));
                default: a = ($urandom_range(0, 1) == 0) ? 32'h600 + 32'($urandom_range(0, 2559)) : ($urandom | 32'h0001_0000);
            endcase
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) | (($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000) : 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            model_access(we, f3, a, wd, mrd, mer);
            exp_q.push_back(mrd); exp_err_q.push_back(mer);
            access(we, f3, a, wd, rd, er, lat, nv);
            e = exp_q.pop_front(); ee = exp_err_q.pop_front();
            checks++; if (rd !== e || er !== ee || lat != 2 || nv != 1)
                begin errors++; $display("FAIL random%0d we %b f3 %b a %h got %h err %b lat %0d want %h err %b lat 2", n, we, f3, a, rd, er, lat, e, ee); end
            if (n % 20 == 19) begin
                checks++; if (io_out_o !== exp_io_out()) begin errors++; $display("FAIL random_out%0d got %h want %h", n, io_out_o, exp_io_out()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_subword();
        test_out_port();
        test_switch();
        test_faults();
        test_misalign();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mmio.md
# lsu_mmio

Parametrised memory-mapped load/store unit for the RV32I pipeline: byte-addressed data RAM, a bank of writable/readable output peripheral registers, and a synchronised switch input region behind one valid/ready request port with a fixed-latency response. Supports full RV32I sub-word access (LB/LH/LW/LBU/LHU, SB/SH/SW) and flags illegal accesses, reserved-region accesses and invalid operations. Sits between the EX/MEM stage and the board I/O; the pipeline stalls on `req_ready_o`.

## Interface
- `DMEM_WORDS`, 256, data RAM depth in 32-bit words; power of two, at most 256.
- `NUM_OUT`, 11, number of 32-bit output registers; at most 64.
- `SW_W`, 17, switch input width; at most 32.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted this cycle when high together with `req_valid_i`.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32I funct3 (size/sign).
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, LSB-aligned.
- `rsp_valid_o` out 1: one-cycle response strobe; no backpressure.
- `rsp_rdata_o` out 32: load data, extended per funct3; 0 for stores and errors.
- `rsp_err_o` out 1: access faulted; valid with `rsp_valid_o`.
- `io_sw_i` in SW_W: asynchronous switch inputs.
- `io_out_o` out NUM_OUT*32: output registers; register k at bits [32k+31:32k] (k=0..7 HEX0-7, 8 LEDR, 9 LEDG, 10 LCD by default).

## Operation
- Byte address map: data 0x000-0x3FF (upper part beyond DMEM_WORDS*4 is reserved); output 0x400-0x4FF (register index = addr[7:2], indices >= NUM_OUT reserved); input 0x500-0x5FF (every word reads the switches); everything at or above 0x600 reserved.
- FSM states: IDLE, ACCESS, RESP. IDLE --accept--> ACCESS --> RESP; RESP --accept--> ACCESS, otherwise --> IDLE.
- `req_ready_o` = 1 in IDLE and RESP, 0 in ACCESS and while `rst_i` is high. The request is captured into registers on accept.
- Loads: data RAM read is registered (read issued at accept, data available in ACCESS); lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend. Output registers read back the stored value. Input region returns the synchronised switches zero-extended to 32 bits.
- Stores: byte-enable from funct3/addr[1:0] (SB one lane, SH lanes {1:0} or {3:2}, SW all four); written on the clock edge that ends ACCESS, to either the RAM or the output register.
- Errors (rsp_err_o=1, no write, rdata 0): reserved region; store to input region; funct3 011/110/111 (or any load funct3 100/101 with `req_we_i`=1); misaligned access when `LSU_MISALIGN_TRAP_EN` is defined.
- Switches go through a 2-flop synchroniser, which is cleared to 0 on reset.

## Timing
- Accept on edge T -> `rsp_valid_o` high for exactly cycle T+2. Back-to-back throughput: one request every 2 cycles.
- `io_out_o` reflects a store from the edge ending ACCESS (visible in RESP).
- A load in RESP that is accepted right after a store to the same word returns the new data.
- A switch change is visible to loads accepted at least 3 cycles later.
- Reset values: state IDLE; `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `io_out_o`=0. The data RAM is not reset.
- Reset asserted in ACCESS: the store is suppressed and no response is produced.
- Reset asserted in RESP: the strobe is dropped the next cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: the following fault with `rsp_err_o`=1 and no write:
  - a halfword at addr[0]=1;
  - a word at addr[1:0]!=0.
- Undefined: the low address bits are forced to natural alignment (a halfword clears addr[0], a word clears addr[1:0]). The access proceeds and never faults for alignment.

## Structure
- `lsu_pkg`: funct3 enum (`LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`), region base/limit constants, region enum (`REG_DATA`, `REG_OUT`, `REG_IN`, `REG_RSVD`), FSM state enum.
- Sub-module `lsu_load_align`: purely combinational lane select and sign/zero extension from a 32-bit word, addr[1:0] and funct3; it is shared by the RAM, output and input paths.

## Test plan
- Reset: hold `rst_i` 2 cycles -> all outputs 0; `req_ready_o`=0 during reset and 1 the cycle after.
- Sub-word load: SW 0x8000_80FF @0x010; then LB @0x010 -> 0xFFFF_FFFF; LBU @0x011 -> 0x0000_0080; LH @0x012 -> 0xFFFF_8000; LHU @0x012 -> 0x0000_8000; each with `rsp_valid_o` at T+2.
- Output port: SB 0xA5 @0x405 -> `io_out_o` reg1 = 0x0000_A500 in RESP; LW @0x404 -> 0x0000_A500.
- Switch input: `io_sw_i`=0x1_2345 then LW @0x500 three cycles later -> 0x0001_2345.
- Faults:
  - SW @0x500 -> err=1, no effect;
  - LW @0x700 -> err=1, rdata 0;
  - funct3 011 -> err=1.
- Misalignment: LW @0x013:
  - with `LSU_MISALIGN_TRAP_EN` -> err=1, no write;
  - without it -> returns the word at 0x010, err=0.
- Reset mid-op: SW @0x020 accepted, `rst_i` raised in ACCESS -> no response; a later LW @0x020 returns the prior content.
